// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: op codes,
// FSM state encoding and the digit-counter width helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Counter must hold 0..NDIG-1; keep at least one bit when NDIG is 1.
  function automatic int cnt_width(input int ndig);
    return (ndig < 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into
// its MSB so the top level can form two's-complement overflow.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s_d  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
      c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract with carry chaining (ADC/SBC), valid/ready on
// both sides, LSB-first, WIDTH/DIGIT cycles per operation.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e            state;
  state_e            state_nx;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  a_nx;
  logic [WIDTH-1:0]  b_nx;
  logic [WIDTH-1:0]  sum_q;
  logic [WIDTH-1:0]  sum_nx;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic              zrun;
  logic              cf;
  logic              cin_init;
  logic              accept;
  logic              last;
  logic [DIGIT-1:0]  s_d;
  logic              d_cout;
  logic              d_cmsb;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d   (a_sh[DIGIT-1:0]),
    .b_d   (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .s_d   (s_d),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // With a single digit there is nothing to shift down.
  if (NDIG == 1) begin : g_single
    assign sum_nx = s_d;
    assign a_nx   = a_sh;
    assign b_nx   = b_sh;
  end else begin : g_multi
    assign sum_nx = {s_d, sum_q[WIDTH-1:DIGIT]};
    assign a_nx   = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
    assign b_nx   = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)    state_nx = ST_RUN;
      ST_RUN:  if (last)      state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !rst;
    out_valid = (state == ST_DONE);
    accept    = in_valid && in_ready;
    last      = (cnt == LAST);
  end

  always_comb begin
    case (op)
      OP_ADD:  cin_init = 1'b0;
      OP_SUB:  cin_init = 1'b1;
      default: cin_init = cf;
    endcase
  end

  // Control and flags; cf only changes when an operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      zrun  <= 1'b0;
      cf    <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      sum_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= cin_init;
      zrun  <= 1'b1;
    end else if (state == ST_RUN) begin
      sum_q <= sum_nx;
      carry <= d_cout;
      zrun  <= zrun & (s_d == '0);
      cnt   <= cnt + 1'b1;
      if (last) begin
        cout <= d_cout;
        ovf  <= d_cout ^ d_cmsb;
        zero <= zrun & (s_d == '0);
        cf   <= d_cout;
      end
    end
  end

  // Operand shift registers carry no control meaning and are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= op[0] ? ~b : b;
    end else if (state == ST_RUN) begin
      a_sh <= a_nx;
      b_sh <= b_nx;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed cases on a 32/4 instance plus a random
// sweep over six WIDTH/DIGIT configurations against an arithmetic model.
module tb_addsub_serial;
  import addsub_pkg::*;

  localparam int NCFG = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_v  [NCFG];
  logic        out_ready_v [NCFG];
  logic [1:0]  op_v        [NCFG];
  logic [31:0] a_v         [NCFG];
  logic [31:0] b_v         [NCFG];
  logic        in_ready_v  [NCFG];
  logic        out_valid_v [NCFG];
  logic        cout_v      [NCFG];
  logic        ovf_v       [NCFG];
  logic        zero_v      [NCFG];
  logic [31:0] sum_v       [NCFG];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cfg_w(input int k);
    return (k < 3) ? 32 : 8;
  endfunction

  function automatic int cfg_d(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 32;
      3: return 1;
      4: return 4;
      default: return 8;
    endcase
  endfunction

  for (genvar k = 0; k < NCFG; k++) begin : g_cfg
    localparam int W = (k < 3) ? 32 : 8;
    localparam int D = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 32 :
                       (k == 3) ? 1 : (k == 4) ? 4 : 8;
    logic [W-1:0] sum_l;
    addsub_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[k]),
      .in_ready  (in_ready_v[k]),
      .a         (a_v[k][W-1:0]),
      .b         (b_v[k][W-1:0]),
      .op        (op_v[k]),
      .out_valid (out_valid_v[k]),
      .out_ready (out_ready_v[k]),
      .sum       (sum_l),
      .cout      (cout_v[k]),
      .ovf       (ovf_v[k]),
      .zero      (zero_v[k])
    );
    assign sum_v[k] = 32'(sum_l);
  end

  // Reference: result = A + (B or ~B) + cin on w-bit unsigned integers.
  function automatic void model(input int w, input logic [1:0] o,
                                input logic [31:0] x, input logic [31:0] y,
                                input logic cfin, output logic [31:0] s,
                                output logic c, output logic v, output logic z);
    longint unsigned mask, xa, yb, ci, t, sx, sy, ss;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'd0, x} & mask;
    yb   = (o == OP_SUB || o == OP_SBC) ? (~{32'd0, y} & mask) : ({32'd0, y} & mask);
    ci   = (o == OP_ADD) ? 64'd0 : (o == OP_SUB) ? 64'd1 : {63'd0, cfin};
    t    = xa + yb + ci;
    s    = 32'(t & mask);
    c    = ((t >> w) & 64'd1) != 0;
    sx   = (xa >> (w - 1)) & 64'd1;
    sy   = (yb >> (w - 1)) & 64'd1;
    ss   = (t >> (w - 1)) & 64'd1;
    v    = (sx == sy) && (ss != sx);
    z    = (t & mask) == 0;
  endfunction

  task automatic do_op(input int k, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] s, output logic c,
                       output logic v, output logic z, output int lat);
    int t;
    t = 0;
    while (!in_ready_v[k] && t < 200) begin @(posedge clk); #1; t++; end
    op_v[k] = o; a_v[k] = x; b_v[k] = y; in_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    lat = 0;
    while (!out_valid_v[k] && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid_v[k]) lat = -1;
    s = sum_v[k]; c = cout_v[k]; v = ovf_v[k]; z = zero_v[k];
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready_v[0], out_valid_v[0], cout_v[0], ovf_v[0], zero_v[0]} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got rdy/vld/c/v/z=%b want 00000",
               {in_ready_v[0], out_valid_v[0], cout_v[0], ovf_v[0], zero_v[0]});
    end
    n_cmp++;
    if (sum_v[0] !== 32'h0) begin
      n_err++; $display("FAIL reset_sum got %h want 00000000", sum_v[0]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready_v[0] !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready got %b want 1", in_ready_v[0]);
    end
  endtask

  task automatic test_add_latency();
    logic [31:0] s; logic c, v, z; int lat;
    do_op(0, OP_ADD, 32'h1, 32'h2, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'h3 || {c, v, z} !== 3'b000) begin
      n_err++; $display("FAIL add_1_2 got sum=%h cvz=%b want 00000003 000", s, {c, v, z});
    end
    n_cmp++;
    if (lat !== 8) begin
      n_err++; $display("FAIL add_latency got %0d want 8", lat);
    end
  endtask

  task automatic test_sub();
    logic [31:0] s; logic c, v, z; int lat;
    do_op(0, OP_SUB, 32'd5, 32'd5, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'h0 || {c, v, z} !== 3'b101) begin
      n_err++; $display("FAIL sub_5_5 got sum=%h cvz=%b want 00000000 101", s, {c, v, z});
    end
    do_op(0, OP_SUB, 32'd0, 32'd1, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'hFFFF_FFFF || {c, v, z} !== 3'b000) begin
      n_err++; $display("FAIL sub_0_1 got sum=%h cvz=%b want ffffffff 000", s, {c, v, z});
    end
    do_op(0, OP_SUB, 32'h8000_0000, 32'd1, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'h7FFF_FFFF || {c, v, z} !== 3'b110) begin
      n_err++; $display("FAIL sub_min_1 got sum=%h cvz=%b want 7fffffff 110", s, {c, v, z});
    end
  endtask

  task automatic test_ovf_chain();
    logic [31:0] s; logic c, v, z; int lat;
    do_op(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'h8000_0000 || {c, v, z} !== 3'b010) begin
      n_err++; $display("FAIL add_max_1 got sum=%h cvz=%b want 80000000 010", s, {c, v, z});
    end
    do_op(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'h0 || {c, v, z} !== 3'b101) begin
      n_err++; $display("FAIL chain_lo got sum=%h cvz=%b want 00000000 101", s, {c, v, z});
    end
    do_op(0, OP_ADC, 32'd0, 32'd0, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'h1 || {c, v, z} !== 3'b000) begin
      n_err++; $display("FAIL chain_hi got sum=%h cvz=%b want 00000001 000", s, {c, v, z});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s; logic c, v, z; int lat, t;
    t = 0;
    while (!in_ready_v[0] && t < 200) begin @(posedge clk); #1; t++; end
    op_v[0] = OP_ADD; a_v[0] = 32'h1234; b_v[0] = 32'h1111; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    t = 0;
    while (!out_valid_v[0] && t < 200) begin @(posedge clk); #1; t++; end
    op_v[0] = OP_SUB; a_v[0] = 32'hDEAD_BEEF; b_v[0] = 32'h0BAD_F00D; in_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid_v[0], in_ready_v[0], sum_v[0], cout_v[0], ovf_v[0], zero_v[0]} !==
          {1'b1, 1'b0, 32'h2345, 3'b000}) begin
        n_err++;
        $display("FAIL bp_hold cyc%0d got vld=%b rdy=%b sum=%h cvz=%b want 1 0 00002345 000",
                 i, out_valid_v[0], in_ready_v[0], sum_v[0], {cout_v[0], ovf_v[0], zero_v[0]});
      end
      @(posedge clk); #1;
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    n_cmp++;
    if ({in_ready_v[0], out_valid_v[0]} !== 2'b10) begin
      n_err++; $display("FAIL bp_release got rdy/vld=%b want 10", {in_ready_v[0], out_valid_v[0]});
    end
    do_op(0, OP_ADD, 32'd1, 32'd1, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'h2 || lat !== 8) begin
      n_err++; $display("FAIL bp_next got sum=%h lat=%0d want 00000002 8", s, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s; logic c, v, z; int lat, t; logic seen;
    do_op(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, s, c, v, z, lat);
    n_cmp++;
    if (c !== 1'b1) begin
      n_err++; $display("FAIL rm_setcf got cout=%b want 1", c);
    end
    t = 0;
    while (!in_ready_v[0] && t < 200) begin @(posedge clk); #1; t++; end
    op_v[0] = OP_ADD; a_v[0] = 32'h1234_5678; b_v[0] = 32'h1111_1111; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid_v[0], in_ready_v[0], sum_v[0], cout_v[0], ovf_v[0], zero_v[0]} !== 37'd0) begin
      n_err++;
      $display("FAIL rm_outputs got vld=%b rdy=%b sum=%h cvz=%b want all zero",
               out_valid_v[0], in_ready_v[0], sum_v[0], {cout_v[0], ovf_v[0], zero_v[0]});
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL rm_abandon got out_valid=1 want 0");
    end
    do_op(0, OP_SBC, 32'h10, 32'h01, s, c, v, z, lat);
    n_cmp++;
    if (s !== 32'h0000_000E || {c, v, z} !== 3'b100) begin
      n_err++; $display("FAIL rm_sbc got sum=%h cvz=%b want 0000000e 100", s, {c, v, z});
    end
  endtask

  task automatic test_random_sweep(input int k, input int nops);
    int w, nd, t, acc, last_acc;
    logic cf, mc, mv, mz;
    logic [1:0] o;
    logic [31:0] x, y, ms;
    w = cfg_w(k);
    nd = w / cfg_d(k);
    cf = 1'b0;
    last_acc = -1;
    out_ready_v[k] = 1'b1;
    in_valid_v[k] = 1'b1;
    for (int i = 0; i < nops; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: x = 32'h0;
        1: y = 32'hFFFF_FFFF;
        2: begin x = 32'(64'd1 << (w - 1)); y = 32'd1; end
        3: y = x;
        default: ;
      endcase
      op_v[k] = o; a_v[k] = x; b_v[k] = y;
      t = 0;
      while (!in_ready_v[k] && t < 300) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      acc = cyc;
      if (last_acc >= 0) begin
        n_cmp++;
        if (acc - last_acc !== nd + 2) begin
          n_err++; $display("FAIL rnd_period cfg%0d op%0d got %0d want %0d", k, i, acc - last_acc, nd + 2);
        end
      end
      last_acc = acc;
      t = 0;
      while (!out_valid_v[k] && t < 300) begin @(posedge clk); #1; t++; end
      model(w, o, x, y, cf, ms, mc, mv, mz);
      cf = mc;
      n_cmp++;
      if (sum_v[k] !== ms || out_valid_v[k] !== 1'b1) begin
        n_err++;
        $display("FAIL rnd_sum cfg%0d op%0d o=%0d a=%h b=%h got %h vld=%b want %h",
                 k, i, o, x, y, sum_v[k], out_valid_v[k], ms);
      end
      n_cmp++;
      if ({cout_v[k], ovf_v[k], zero_v[k]} !== {mc, mv, mz}) begin
        n_err++;
        $display("FAIL rnd_flags cfg%0d op%0d o=%0d a=%h b=%h got cvz=%b want %b",
                 k, i, o, x, y, {cout_v[k], ovf_v[k], zero_v[k]}, {mc, mv, mz});
      end
    end
    in_valid_v[k] = 1'b0;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NCFG; k++) begin
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      op_v[k] = 2'b00; a_v[k] = '0; b_v[k] = '0;
    end
    #1;
    test_reset();
    test_add_latency();
    test_sub();
    test_ovf_chain();
    test_backpressure();
    test_reset_mid();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NCFG; k++) test_random_sweep(k, 400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
